// File: rtl/rf_scoreboard_if.sv
// Decode/writeback side signals of the register-file hazard scoreboard.
// The master drives issue/retire/flush; the slave (scoreboard) drives the status.
interface rf_scoreboard_if;
   logic       issue_vld;
   logic       issue_wr;
   logic [2:0] issue_dst;
   logic       src1_vld;
   logic [2:0] src1_sel;
   logic       src2_vld;
   logic [2:0] src2_sel;
   logic       retire_vld;
   logic [2:0] retire_dst;
   logic       flush;
   logic       stall;
   logic       issue_ack;
   logic [7:0] pend;
   logic       busy;
   logic       err;

   modport master (
      output issue_vld, issue_wr, issue_dst,
      output src1_vld, src1_sel, src2_vld, src2_sel,
      output retire_vld, retire_dst, flush,
      input  stall, issue_ack, pend, busy, err
   );

   modport slave (
      input  issue_vld, issue_wr, issue_dst,
      input  src1_vld, src1_sel, src2_vld, src2_sel,
      input  retire_vld, retire_dst, flush,
      output stall, issue_ack, pend, busy, err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: per-register outstanding-write counters,
// RAW / write-limit stall generation and sticky retire-underflow error.
module rf_scoreboard #(
   parameter int unsigned MAXPEND = 3
) (
   input  logic           clk,
   input  logic           rst,
   rf_scoreboard_if.slave sb
);

   localparam logic [1:0] MAX_CNT = 2'(MAXPEND);

   logic [1:0] cnt     [8];
   logic [1:0] cnt_nxt [8];
   logic [7:0] pend_q;
   logic [7:0] pend_nxt;
   logic       busy_q;
   logic       err_q;
   logic       err_nxt;
   logic [7:0] inc;
   logic [7:0] dec;
   logic       h1, h2, hw;
   logic       stall;
   logic       ack;

   // Hazards look only at registered state; a retire in the same cycle does not bypass.
   always_comb begin
      h1    = sb.src1_vld & pend_q[sb.src1_sel];
      h2    = sb.src2_vld & pend_q[sb.src2_sel];
      hw    = sb.issue_wr & (cnt[sb.issue_dst] == MAX_CNT);
      stall = sb.issue_vld & (h1 | h2 | hw);
      ack   = sb.issue_vld & ~stall & ~sb.flush;
   end

   always_comb begin
      inc      = '0;
      dec      = '0;
      pend_nxt = '0;
      err_nxt  = err_q;
      for (int unsigned i = 0; i < 8; i++) begin
         inc[i]     = ack & sb.issue_wr & (sb.issue_dst == 3'(i));
         dec[i]     = sb.retire_vld & (sb.retire_dst == 3'(i)) & (cnt[i] != '0);
         cnt_nxt[i] = cnt[i];
         if (sb.flush)
            cnt_nxt[i] = '0;
         else if (inc[i] & ~dec[i])
            cnt_nxt[i] = cnt[i] + 2'd1;
         else if (dec[i] & ~inc[i])
            cnt_nxt[i] = cnt[i] - 2'd1;
         pend_nxt[i] = (cnt_nxt[i] != '0);
      end
      if (~sb.flush & sb.retire_vld & (cnt[sb.retire_dst] == '0))
         err_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '{default: '0};
         pend_q <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         pend_q <= pend_nxt;
         busy_q <= |pend_nxt;
         err_q  <= err_nxt;
      end
   end

   assign sb.stall     = stall;
   assign sb.issue_ack = ack;
   assign sb.pend      = pend_q;
   assign sb.busy      = busy_q;
   assign sb.err       = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed hazard scenarios plus random
// traffic, checked against an integer reference model through an expectation queue.
module tb_rf_scoreboard;

   typedef struct {
      logic [7:0] pend;
      logic       busy;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   m_cnt [8];
   bit   m_err;
   exp_t exp_q [$];

   rf_scoreboard_if sb_if ();

   rf_scoreboard #(.MAXPEND(3)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_err = 1'b0;
   endtask

   task automatic drive_idle();
      sb_if.issue_vld  = 1'b0;
      sb_if.issue_wr   = 1'b0;
      sb_if.issue_dst  = 3'd0;
      sb_if.src1_vld   = 1'b0;
      sb_if.src1_sel   = 3'd0;
      sb_if.src2_vld   = 1'b0;
      sb_if.src2_sel   = 3'd0;
      sb_if.retire_vld = 1'b0;
      sb_if.retire_dst = 3'd0;
      sb_if.flush      = 1'b0;
   endtask

   // One clock of stimulus: check stall/ack now, queue expected state, check after the edge.
   task automatic step(input bit vld, input bit wr, input int dst,
                       input bit s1v, input int s1, input bit s2v, input int s2,
                       input bit rv, input int rd, input bit fl);
      bit   e_stall, e_ack;
      exp_t e;
      exp_t got;
      sb_if.issue_vld  = vld;
      sb_if.issue_wr   = wr;
      sb_if.issue_dst  = 3'(dst);
      sb_if.src1_vld   = s1v;
      sb_if.src1_sel   = 3'(s1);
      sb_if.src2_vld   = s2v;
      sb_if.src2_sel   = 3'(s2);
      sb_if.retire_vld = rv;
      sb_if.retire_dst = 3'(rd);
      sb_if.flush      = fl;
      #1;
      e_stall = vld && ((s1v && m_cnt[s1] > 0) || (s2v && m_cnt[s2] > 0) || (wr && m_cnt[dst] == 3));
      e_ack   = vld && !e_stall && !fl;
      chk("stall", 32'(sb_if.stall), 32'(e_stall));
      chk("issue_ack", 32'(sb_if.issue_ack), 32'(e_ack));
      if (fl) begin
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else begin
         if (rv && m_cnt[rd] == 0) m_err = 1'b1;
         else if (rv) m_cnt[rd] = m_cnt[rd] - 1;
         if (e_ack && wr) m_cnt[dst] = m_cnt[dst] + 1;
      end
      e.pend = '0;
      for (int i = 0; i < 8; i++) e.pend[i] = (m_cnt[i] != 0);
      e.busy = (e.pend != 8'h00);
      e.err  = m_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("pend", 32'(sb_if.pend), 32'(got.pend));
      chk("busy", 32'(sb_if.busy), 32'(got.busy));
      chk("err", 32'(sb_if.err), 32'(got.err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive_idle();
      model_reset();
      // Reset with a read of R2 presented
      sb_if.issue_vld = 1'b1;
      sb_if.src1_vld  = 1'b1;
      sb_if.src1_sel  = 3'd2;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_pend", 32'(sb_if.pend), 32'h00);
      chk("rst_busy", 32'(sb_if.busy), 32'h0);
      chk("rst_err", 32'(sb_if.err), 32'h0);
      chk("rst_stall", 32'(sb_if.stall), 32'h0);
      rst = 1'b0;
      step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);

      // RAW on R3, released one cycle after retire
      step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
      step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);

      // Write-limit saturation on R7
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

      // Simultaneous issue and retire
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
      step(1, 1, 4, 0, 0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 1, 4, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);

      // Underflow then flush
      step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
      for (int i = 0; i < 4; i++) step(1, 1, i, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 6, 0, 0, 0, 0, 1, 2, 1);
      step(1, 0, 0, 1, 0, 1, 3, 0, 0, 0);

      // Fill all registers, then async reset between edges
      for (int i = 0; i < 8; i++) step(1, 1, i, 0, 0, 0, 0, 0, 0, 0);
      drive_idle();
      #3;
      rst = 1'b1;
      #1;
      chk("async_pend", 32'(sb_if.pend), 32'h00);
      chk("async_busy", 32'(sb_if.busy), 32'h0);
      chk("async_err", 32'(sb_if.err), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 2) != 0, $urandom_range(0, 7),
              $urandom_range(0, 30) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
